bram_loader: RTL
================

# bram_loader

Upstream write-side stage for the dual-port block RAM. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive RAM addresses through one RAM port, starting at a programmed base address. It sits between the UART/boot byte source and the RAM's write port, and is used to load program or data images before the CPU is released. It also reports a running 16-bit checksum of the words written.

## Interface
- DATA_WIDTH, 16: RAM word width; fixed at 16, two bytes per word.
- ADDR_WIDTH, 10: RAM address width; matches the RAM instance.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a transfer; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first RAM address; sampled with start.
- word_count  input  ADDR_WIDTH+1  number of words to write, 0..2**ADDR_WIDTH; sampled with start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_WIDTH  RAM address; connects to the RAM port addr.
- mem_data  output  DATA_WIDTH  RAM write data.
- mem_we  output  1  RAM write enable; one cycle per word.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when the transfer completes.
- checksum  output  16  sum of written words, mod 2^16.

## Operation
- States: IDLE, HI, LO, WRITE, DONE.
- IDLE: in_ready=0, busy=0.
  - start=1 latches base_addr into the address counter and word_count into the remaining counter, and clears checksum.
  - Next state is HI when word_count≠0, otherwise DONE.
- HI: in_ready=1. A byte transfer happens on an edge where in_valid && in_ready. It stores in_data as the high byte, then goes to LO. With no transfer, the loader stays in HI indefinitely.
- LO: in_ready=1. A transfer stores the low byte, then goes to WRITE.
- WRITE: in_ready=0, mem_we=1, mem_addr=address counter, mem_data={hi,lo}.
  - On the edge: checksum += mem_data (mod 2^16), remaining decrements, and the address counter increments modulo 2**ADDR_WIDTH (0x3FF wraps to 0x000).
  - Next state is DONE when remaining was 1, otherwise HI.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- checksum holds its final value after DONE until the next accepted start.
- start while busy (any state other than IDLE) is ignored. base_addr and word_count changes while busy are ignored.
- in_data arriving while in_ready=0 is not consumed; the source must hold it.
- word_count=2**ADDR_WIDTH fills the whole RAM exactly once.
- reset (any state, including mid-transfer):
  - Effect on the next edge: state=IDLE and all outputs 0 (in_ready, mem_addr, mem_data, mem_we, busy, done, checksum).
  - Internal counters and byte registers are cleared.
  - Words already written stay in RAM. No further write occurs; a partially assembled word is discarded.
- mem_we is never asserted outside WRITE. mem_addr and mem_data are don't-care when mem_we=0 but are driven registered values, never X after reset.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or start to any output.
- start accepted on edge N puts the loader in HI at cycle N+1 with in_ready=1 and busy=1.
- Minimum 3 cycles per word (HI, LO, WRITE) when in_valid is held high.
- The low byte accepted on edge M puts mem_we high during cycle M+1. The RAM captures the word on edge M+2's rising clock, i.e. the edge ending the WRITE cycle.
- For the last word, done is high during the cycle after WRITE, and checksum is final in that same cycle.
- word_count=0: start on edge N, DONE during cycle N+1, IDLE at N+2; no mem_we.
- Back-to-back transfers: start may be accepted in the first IDLE cycle after DONE.

## Test plan
- Reset: assert reset 2 cycles mid-stream -> next cycle in_ready=0, mem_we=0, busy=0, done=0, checksum=0x0000, mem_addr=0.
- Basic load: base_addr=0x010, word_count=3, bytes 12 34 AB CD 00 FF with in_valid held high -> writes 0x1234@0x010, 0xABCD@0x011, 0x00FF@0x012, one mem_we pulse each 3 cycles apart; single done pulse; checksum=0xBF00; RAM readback matches.
- Backpressure/gaps: same stream with in_valid randomly deasserted and bytes held -> identical writes and checksum; no byte duplicated or lost; in_ready low in WRITE.
- Wrap-around: base_addr=0x3FF, word_count=2, bytes 11 11 22 22 -> 0x1111@0x3FF, 0x2222@0x000; checksum=0x3333.
- Zero count and ignored start: word_count=0 -> done two cycles after start, no mem_we, checksum=0. Pulse start mid-transfer with a different base_addr -> no effect on addresses.
- Reset mid-operation: reset after the first of 3 words written -> only the first word in RAM; no later mem_we. A fresh start afterwards loads correctly from its own base_addr.

Source files
------------

// File: rtl/bram_loader.sv
// bram_loader
//
// Write-side loader for the dual-port block RAM. Accepts a byte stream over
// a valid/ready handshake, packs pairs of bytes into big-endian 16-bit words
// and writes them to consecutive RAM addresses starting at base_addr. A
// running 16-bit checksum of all written words is kept.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on registered state, so the
// source may hold in_data/in_valid indefinitely while in_ready is low.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   start            begin a transfer (sampled only in IDLE)
//   base_addr        first RAM address (sampled with start)
//   word_count       words to write, 0..2**ADDR_WIDTH (sampled with start)
//   in_data/in_valid/in_ready  byte stream handshake
//   mem_addr/mem_data/mem_we   RAM write port
//   busy             high from the cycle after start until DONE is left
//   done             one-cycle completion pulse
//   checksum         sum of written words, mod 2^16
//   fsm_state        current FSM state, for debug and checker binding
module bram_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic [7:0]            hi_byte;
    logic [7:0]            lo_byte;

    assign mem_addr  = addr_cnt;
    assign mem_data  = {hi_byte, lo_byte};
    assign fsm_state = state;

    // Outputs are registered alongside the state: each transition sets the
    // output values that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            lo_byte   <= '0;
            checksum  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        addr_cnt  <= base_addr;
                        remaining <= word_count;
                        checksum  <= '0;
                        busy      <= 1'b1;
                        if (word_count != '0) begin
                            state    <= S_HI;
                            in_ready <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        hi_byte <= in_data;
                        state   <= S_LO;
                    end
                end
                S_LO: begin
                    if (in_valid) begin
                        lo_byte  <= in_data;
                        state    <= S_WRITE;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    checksum  <= checksum + mem_data;
                    remaining <= remaining - CNT_ONE;
                    addr_cnt  <= addr_cnt + ADDR_ONE;
                    if (remaining == CNT_ONE) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_HI;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
